// File: rtl/tb_reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_pkg
//  Description : Shared types and helpers for the system reset sequencer:
//                sequencer state encoding and lowest-set-bit isolation.
//  Revision    : 1.0  initial release
// ============================================================================
package tb_reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_STAGGER = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // One-hot of the lowest set bit of v (zero when v is zero).
  function automatic logic [31:0] lowest_set_bit(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_hold_counter.sv
`default_nettype none
// ============================================================================
//  Module      : reset_hold_counter
//  Description : Loadable down-counter with zero flag. Decrement saturates at
//                zero so a stalled sequence can never wrap back to a long hold.
//  Revision    : 1.0  initial release
// ============================================================================
module reset_hold_counter #(
  parameter int CNT_W       = 16,
  parameter int RESET_VALUE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority over decrement; decrement holds at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= CNT_W'(RESET_VALUE);
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/system_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : system_reset_sequencer
//  Description : Multi-channel reset generator. Runs a power-on sequence out
//                of reset, then services re-reset requests from a valid/ready
//                port or a DPI-C call: selected channels are held for a
//                clamped hold time, then released one per STAGGER_CYCLES,
//                lowest index first.
//  Revision    : 1.0  initial release
// ============================================================================
module system_reset_sequencer
  import tb_reset_pkg::*;
#(
  parameter int NUM_CHANNELS      = 4,
  parameter int MIN_ASSERT_CYCLES = 8,
  parameter int STAGGER_CYCLES    = 4,
  parameter int CNT_W             = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NUM_CHANNELS-1:0] req_mask,
  input  logic [CNT_W-1:0]        req_cycles,
  output logic [NUM_CHANNELS-1:0] out,
  output logic                    busy,
  output logic                    done
);

  localparam logic [CNT_W-1:0]        MIN_HOLD       = CNT_W'(MIN_ASSERT_CYCLES);
  // The release edge itself is one of the STAGGER_CYCLES, so reload one less.
  localparam logic [CNT_W-1:0]        STAGGER_RELOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [NUM_CHANNELS-1:0] ALL_CHANNELS   = '1;

  state_t                  state, state_next;
  logic [NUM_CHANNELS-1:0] active_mask, active_next;
  logic [NUM_CHANNELS-1:0] out_next;
  logic [NUM_CHANNELS-1:0] release_bit;
  logic [NUM_CHANNELS-1:0] sel_mask;
  logic [CNT_W-1:0]        sel_cycles;
  logic                    cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]        cnt_load_value;
  logic                    dpi_pending, take_dpi;
  logic [NUM_CHANNELS-1:0] dpi_mask;
  logic [CNT_W-1:0]        dpi_cycles;

  function automatic logic [CNT_W-1:0] clamp_hold(input logic [CNT_W-1:0] c);
    return (c < MIN_HOLD) ? MIN_HOLD : c;
  endfunction

  assign release_bit = NUM_CHANNELS'(lowest_set_bit(32'(active_mask)));

  // Port request takes priority; a pending DPI request waits behind it.
  assign sel_mask   = req_valid ? req_mask   : dpi_mask;
  assign sel_cycles = req_valid ? req_cycles : dpi_cycles;

  // One counter serves both the hold phase and the stagger gaps.
  reset_hold_counter #(
    .CNT_W       (CNT_W),
    .RESET_VALUE (MIN_ASSERT_CYCLES)
  ) u_hold_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // State register plus registered channel outputs and active mask.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_ASSERT;
      active_mask <= ALL_CHANNELS;
      out         <= ALL_CHANNELS;
    end else begin
      state       <= state_next;
      active_mask <= active_next;
      out         <= out_next;
    end
  end

  // Next-state, counter control and channel updates.
  always_comb begin
    state_next     = state;
    active_next    = active_mask;
    out_next       = out;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
    take_dpi       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid || dpi_pending) begin
          take_dpi       = !req_valid;
          active_next    = sel_mask;
          out_next       = out | sel_mask;
          cnt_load       = 1'b1;
          cnt_load_value = clamp_hold(sel_cycles);
          state_next     = (sel_mask == '0) ? ST_DONE : ST_ASSERT;
        end
      end
      ST_ASSERT, ST_STAGGER: begin
        if (cnt_zero) begin
          active_next    = active_mask & ~release_bit;
          out_next       = out & ~release_bit;
          cnt_load       = 1'b1;
          cnt_load_value = STAGGER_RELOAD;
          state_next     = ((active_mask & ~release_bit) == '0) ? ST_DONE : ST_STAGGER;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

`ifndef SYNTHESIS
  // A DPI call flips call_toggle; the request is pending while the two
  // toggles differ, so repeated calls simply overwrite the captured values.
  logic                    dpi_call_toggle = 1'b0;
  logic                    dpi_seen_toggle;
  logic [NUM_CHANNELS-1:0] dpi_call_mask;
  logic [CNT_W-1:0]        dpi_call_cycles;

  function void system_reset_sequencer_request(input longint mask, input longint cycles);
    dpi_call_mask   = mask[NUM_CHANNELS-1:0];
    dpi_call_cycles = cycles[CNT_W-1:0];
    dpi_call_toggle = ~dpi_call_toggle;
  endfunction

  // Acknowledge on acceptance; reset discards anything outstanding.
  always_ff @(posedge clock) begin
    if (reset || take_dpi) begin
      dpi_seen_toggle <= dpi_call_toggle;
    end
  end

  assign dpi_pending = dpi_call_toggle ^ dpi_seen_toggle;
  assign dpi_mask    = dpi_call_mask;
  assign dpi_cycles  = dpi_call_cycles;
`else
  assign dpi_pending = 1'b0;
  assign dpi_mask    = '0;
  assign dpi_cycles  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_system_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_system_reset_sequencer
//  Description : Directed vector bench for system_reset_sequencer
//                (4 channels, hold floor 8, stagger 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_system_reset_sequencer;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_mask;
  logic [15:0] req_cycles;
  logic [3:0]  out;
  logic        busy;
  logic        done;

  system_reset_sequencer #(
    .NUM_CHANNELS      (4),
    .MIN_ASSERT_CYCLES (8),
    .STAGGER_CYCLES    (4),
    .CNT_W             (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mask   (req_mask),
    .req_cycles (req_cycles),
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  // Free-running harness clock.
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    bit          is_req;
    logic [3:0]  mask;
    logic [15:0] cycles;
    int          at;
    logic [3:0]  e_out;
    logic        e_busy;
    logic        e_done;
    logic        e_ready;
  } vec_t;

  int   applied;
  int   miscompares;
  int   cyc;
  int   dones;
  vec_t po[$];
  vec_t vecs[$];
  vec_t dpiv[$];

  function automatic vec_t chk(string n, int at, logic [3:0] o, logic b, logic d, logic r);
    vec_t v;
    v.name = n; v.is_req = 1'b0; v.mask = '0; v.cycles = '0; v.at = at;
    v.e_out = o; v.e_busy = b; v.e_done = d; v.e_ready = r;
    return v;
  endfunction

  function automatic vec_t req(string n, logic [3:0] m, logic [15:0] c);
    vec_t v;
    v = chk(n, 0, 4'h0, 1'b0, 1'b0, 1'b0);
    v.is_req = 1'b1; v.mask = m; v.cycles = c;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [3:0] eo, input logic eb,
                       input logic ed, input logic er);
    applied++;
    if (out !== eo || busy !== eb || done !== ed || req_ready !== er) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got out=%h busy=%b done=%b ready=%b, expected out=%h busy=%b done=%b ready=%b",
               name, cyc, out, busy, done, req_ready, eo, eb, ed, er);
    end
  endtask

  // Request: driven in an IDLE cycle, accepted on the next edge (cyc 0).
  task automatic request(input logic [3:0] m, input logic [15:0] c);
    req_valid  = 1'b1;
    req_mask   = m;
    req_cycles = c;
    tick();
    cyc       = 0;
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.is_req) begin
      request(v.mask, v.cycles);
    end else begin
      while (cyc < v.at) tick();
      check(v.name, v.e_out, v.e_busy, v.e_done, v.e_ready);
    end
  endtask

  task automatic run_power_on();
    foreach (po[i]) run_vec(po[i]);
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    cyc         = 0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_mask    = '0;
    req_cycles  = '0;

    // Power-on: cycle counts relative to reset falling.
    po.push_back(chk("po_reset",   0, 4'hF, 1, 0, 0));
    po.push_back(chk("po_hold8",   8, 4'hF, 1, 0, 0));
    po.push_back(chk("po_rel0",    9, 4'hE, 1, 0, 0));
    po.push_back(chk("po_gap0",   12, 4'hE, 1, 0, 0));
    po.push_back(chk("po_rel1",   13, 4'hC, 1, 0, 0));
    po.push_back(chk("po_gap1",   16, 4'hC, 1, 0, 0));
    po.push_back(chk("po_rel2",   17, 4'h8, 1, 0, 0));
    po.push_back(chk("po_gap2",   20, 4'h8, 1, 0, 0));
    po.push_back(chk("po_done",   21, 4'h0, 1, 1, 0));
    po.push_back(chk("po_idle",   22, 4'h0, 0, 0, 1));

    // Port requests: cycle counts relative to the accepting edge.
    vecs.push_back(req("m1010",  4'b1010, 16'd20));
    vecs.push_back(chk("m1010_set",     0, 4'hA, 1, 0, 0));
    vecs.push_back(chk("m1010_hold",   20, 4'hA, 1, 0, 0));
    vecs.push_back(chk("m1010_rel1",   21, 4'h8, 1, 0, 0));
    vecs.push_back(chk("m1010_gap",    24, 4'h8, 1, 0, 0));
    vecs.push_back(chk("m1010_done",   25, 4'h0, 1, 1, 0));
    vecs.push_back(chk("m1010_idle",   26, 4'h0, 0, 0, 1));
    vecs.push_back(req("clamp2", 4'b0001, 16'd2));
    vecs.push_back(chk("clamp2_set",    0, 4'h1, 1, 0, 0));
    vecs.push_back(chk("clamp2_hold",   8, 4'h1, 1, 0, 0));
    vecs.push_back(chk("clamp2_done",   9, 4'h0, 1, 1, 0));
    vecs.push_back(chk("clamp2_idle",  10, 4'h0, 0, 0, 1));
    vecs.push_back(req("mask0",  4'b0000, 16'd5));
    vecs.push_back(chk("mask0_done",    0, 4'h0, 1, 1, 0));
    vecs.push_back(chk("mask0_idle",    1, 4'h0, 0, 0, 1));
    vecs.push_back(req("clamp0", 4'b0110, 16'd0));
    vecs.push_back(chk("clamp0_set",    0, 4'h6, 1, 0, 0));
    vecs.push_back(chk("clamp0_hold",   8, 4'h6, 1, 0, 0));
    vecs.push_back(chk("clamp0_rel1",   9, 4'h4, 1, 0, 0));
    vecs.push_back(chk("clamp0_done",  13, 4'h0, 1, 1, 0));
    vecs.push_back(chk("clamp0_idle",  14, 4'h0, 0, 0, 1));

    // Port (mask 4, hold 8) then queued DPI (mask 1, hold 10).
    dpiv.push_back(chk("dpi_port_set",  0, 4'h4, 1, 0, 0));
    dpiv.push_back(chk("dpi_port_done", 9, 4'h0, 1, 1, 0));
    dpiv.push_back(chk("dpi_idle",     10, 4'h0, 0, 0, 1));
    dpiv.push_back(chk("dpi_set",      11, 4'h1, 1, 0, 0));
    dpiv.push_back(chk("dpi_hold",     21, 4'h1, 1, 0, 0));
    dpiv.push_back(chk("dpi_done",     22, 4'h0, 1, 1, 0));
    dpiv.push_back(chk("dpi_end",      23, 4'h0, 0, 0, 1));

    // 1. Power-on after three reset cycles.
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cyc   = 0;
    run_power_on();

    // 2/3. Table of port requests.
    foreach (vecs[i]) run_vec(vecs[i]);

    // 4. Reset during STAGGER after one release, then full power-on again.
    request(4'hF, 16'd8);
    while (cyc < 10) tick();
    check("mid_stagger", 4'hE, 1, 0, 0);
    reset = 1'b1;
    tick();
    check("mid_reset", 4'hF, 1, 0, 0);
    reset = 1'b0;
    cyc   = 0;
    run_power_on();

    // 5. DPI and port request in the same IDLE cycle.
    dut.system_reset_sequencer_request(64'd1, 64'd10);
    request(4'h4, 16'd0);
    foreach (dpiv[i]) run_vec(dpiv[i]);

    // 6. req_valid held across a busy sequence: second request waits for IDLE.
    req_valid  = 1'b1;
    req_mask   = 4'h2;
    req_cycles = 16'd8;
    tick();
    cyc      = 0;
    req_mask = 4'h8;
    dones    = 0;
    check("hold_first", 4'h2, 1, 0, 0);
    while (cyc < 22) begin
      tick();
      if (done === 1'b1) dones++;
      if (cyc == 5)  check("hold_busy",   4'h2, 1, 0, 0);
      if (cyc == 10) check("hold_idle",   4'h0, 0, 0, 1);
      if (cyc == 11) begin
        check("hold_accept", 4'h8, 1, 0, 0);
        req_valid = 1'b0;
      end
      if (cyc == 21) check("hold_end",   4'h0, 0, 0, 1);
    end
    applied++;
    if (dones != 2) begin
      miscompares++;
      $display("FAIL done_count: got %0d done pulses, expected 2", dones);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
